vend_machine: RTL and testbench

- Coin-operated vending controller. It accepts 5/10/25-cent coins, accumulates credit, and compares the credit against a programmable price (`amount`) when `buy` is requested.
- On a successful purchase or a refund request it dispenses change as single-coin return pulses, honouring coin-tube empty flags.
- It sits between the coin acceptor/dispenser hardware and the product-release logic. `ok` is the product-release strobe.

---
 rtl/vend_pkg.sv | 16 +
 rtl/vend_edge_det.sv | 25 ++
 rtl/vend_machine.sv | 162 ++++++++++++++++
 tb/tb_vend_machine.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
package vend_pkg;

   localparam int unsigned CW_DEFAULT = 9;

   localparam int unsigned C5  = 5;
   localparam int unsigned C10 = 10;
   localparam int unsigned C25 = 25;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      GAP      = 2'd2
   } state_t;

endpackage

// File: rtl/vend_edge_det.sv
// Per-bit rising-edge detector. The previous-value flops load the live
// input during reset, so a level held through reset produces no event.
//   clk, reset : clock and synchronous active-high reset
//   din        : input levels
//   rise_c     : combinational rising-edge flags (prev=0, cur=1)
module vend_edge_det #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] rise_c
);

   logic [W-1:0] prev;

   // Previous-value register; preloaded with the live level in reset.
   always_ff @(posedge clk) begin
      if (reset) prev <= din;
      else       prev <= din;
   end

   assign rise_c = din & ~prev;

endmodule

// File: rtl/vend_machine.sv
// Coin-operated vending controller: accumulates 5/10/25 credit, sells at a
// programmable price and pays change/refunds one coin per pulse.
//   clk, reset                  : clock, synchronous active-high reset
//   detect_5/10/25              : coin-present levels
//   amount                      : price in cents
//   buy, return_coins           : purchase / refund request levels
//   empty_5/10/25               : dispenser tube empty flags
//   ok                          : purchase accepted pulse
//   return_5/10/25              : dispense-one-coin pulses
module vend_machine
   import vend_pkg::*;
#(
   parameter int unsigned CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          detect_5,
   input  logic          detect_10,
   input  logic          detect_25,
   input  logic [CW-1:0] amount,
   input  logic          buy,
   input  logic          return_coins,
   input  logic          empty_5,
   input  logic          empty_10,
   input  logic          empty_25,
   output logic          ok,
   output logic          return_5,
   output logic          return_10,
   output logic          return_25
);

   localparam int unsigned SW = CW + 1;
   localparam logic [SW-1:0] CMAX = {1'b0, {CW{1'b1}}};

   state_t        state, state_nxt;
   logic [CW-1:0] credit, credit_nxt;
   logic [CW-1:0] change, change_nxt;
   logic          ok_nxt, r5_nxt, r10_nxt, r25_nxt;

   logic [4:0]    lvl, rise_c;
   logic          ev5_c, ev10_c, ev25_c, buy_ev_c, ret_ev_c;
   logic          can_buy_c, sel25_c, sel10_c, sel5_c;
   logic [SW-1:0] coin_sum_c, credit_base_c, credit_total_c;

   assign lvl = {return_coins, buy, detect_25, detect_10, detect_5};

   vend_edge_det #(.W(5)) u_edge (
      .clk    (clk),
      .reset  (reset),
      .din    (lvl),
      .rise_c (rise_c)
   );

   assign ev5_c    = rise_c[0];
   assign ev10_c   = rise_c[1];
   assign ev25_c   = rise_c[2];
   assign buy_ev_c = rise_c[3];
   assign ret_ev_c = rise_c[4];

   assign coin_sum_c = (ev5_c  ? SW'(C5)  : '0)
                     + (ev10_c ? SW'(C10) : '0)
                     + (ev25_c ? SW'(C25) : '0);

   assign can_buy_c = credit >= amount;

   // Greedy coin choice, largest available denomination first.
   assign sel25_c = (change >= CW'(C25)) && !empty_25;
   assign sel10_c = !sel25_c && (change >= CW'(C10)) && !empty_10;
   assign sel5_c  = !sel25_c && !sel10_c && (change >= CW'(C5)) && !empty_5;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (buy_ev_c) begin
               if (can_buy_c && (credit != amount)) state_nxt = DISPENSE;
            end else if (ret_ev_c && (credit != '0)) begin
               state_nxt = DISPENSE;
            end
         end
         DISPENSE: state_nxt = (sel25_c || sel10_c || sel5_c) ? GAP : IDLE;
         GAP:      state_nxt = (change != '0) ? DISPENSE : IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      ok_nxt        = 1'b0;
      r5_nxt        = 1'b0;
      r10_nxt       = 1'b0;
      r25_nxt       = 1'b0;
      change_nxt    = change;
      credit_base_c = SW'(credit);
      unique case (state)
         IDLE: begin
            // buy wins over a simultaneous refund request
            if (buy_ev_c) begin
               if (can_buy_c) begin
                  ok_nxt        = 1'b1;
                  change_nxt    = credit - amount;
                  credit_base_c = '0;
               end
            end else if (ret_ev_c) begin
               change_nxt    = credit;
               credit_base_c = '0;
            end
         end
         DISPENSE: begin
            if (sel25_c) begin
               r25_nxt    = 1'b1;
               change_nxt = change - CW'(C25);
            end else if (sel10_c) begin
               r10_nxt    = 1'b1;
               change_nxt = change - CW'(C10);
            end else if (sel5_c) begin
               r5_nxt     = 1'b1;
               change_nxt = change - CW'(C5);
            end else begin
               // undispensable remainder goes back to credit
               credit_base_c = SW'(credit) + SW'(change);
               change_nxt    = '0;
            end
         end
         default: ;
      endcase
      // Coins that would overflow the credit are discarded for this cycle.
      credit_total_c = credit_base_c + coin_sum_c;
      if (credit_total_c > CMAX) begin
         credit_nxt = (credit_base_c > CMAX) ? CW'(CMAX) : CW'(credit_base_c);
      end else begin
         credit_nxt = CW'(credit_total_c);
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         credit    <= '0;
         change    <= '0;
         ok        <= 1'b0;
         return_5  <= 1'b0;
         return_10 <= 1'b0;
         return_25 <= 1'b0;
      end else begin
         credit    <= credit_nxt;
         change    <= change_nxt;
         ok        <= ok_nxt;
         return_5  <= r5_nxt;
         return_10 <= r10_nxt;
         return_25 <= r25_nxt;
      end
   end

endmodule

// File: tb/tb_vend_machine.sv
// Directed bench for vend_machine with hand-computed expectations.
module tb_vend_machine;
   import vend_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       detect_5, detect_10, detect_25;
   logic [8:0] amount;
   logic       buy, return_coins;
   logic       empty_5, empty_10, empty_25;
   logic       ok, return_5, return_10, return_25;

   int n_cmp = 0;
   int n_err = 0;

   int n_ok, n5, n10, n25, n_multi;
   int seq[$];
   int cyc[$];

   vend_machine #(.CW(9)) dut (
      .clk          (clk),
      .reset        (reset),
      .detect_5     (detect_5),
      .detect_10    (detect_10),
      .detect_25    (detect_25),
      .amount       (amount),
      .buy          (buy),
      .return_coins (return_coins),
      .empty_5      (empty_5),
      .empty_10     (empty_10),
      .empty_25     (empty_25),
      .ok           (ok),
      .return_5     (return_5),
      .return_10    (return_10),
      .return_25    (return_25)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int outs();
      return int'(ok) + int'(return_5) + int'(return_10) + int'(return_25);
   endfunction

   task automatic watch(input int n);
      n_ok = 0; n5 = 0; n10 = 0; n25 = 0; n_multi = 0;
      seq.delete();
      cyc.delete();
      for (int i = 0; i < n; i++) begin
         tick();
         if (outs() > 1) n_multi++;
         if (ok) n_ok++;
         if (return_25) begin n25++; seq.push_back(25); cyc.push_back(i); end
         if (return_10) begin n10++; seq.push_back(10); cyc.push_back(i); end
         if (return_5)  begin n5++;  seq.push_back(5);  cyc.push_back(i); end
      end
   endtask

   task automatic coin(input int v);
      detect_5  = (v == 5);
      detect_10 = (v == 10);
      detect_25 = (v == 25);
      repeat (10) tick();
      detect_5 = 0; detect_10 = 0; detect_25 = 0;
      repeat (2) tick();
   endtask

   task automatic do_buy(input int n);
      buy = 1;
      watch(n);
      buy = 0;
      tick();
   endtask

   task automatic do_return(input int n);
      return_coins = 1;
      watch(n);
      return_coins = 0;
      tick();
   endtask

   task automatic do_reset();
      reset = 1;
      repeat (2) tick();
      reset = 0;
      tick();
   endtask

   initial begin
      int got;
      reset = 1; detect_5 = 0; detect_10 = 1; detect_25 = 0;
      amount = '0; buy = 0; return_coins = 0;
      empty_5 = 0; empty_10 = 0; empty_25 = 0;

      // Reset state; detect_10 held through reset must not credit.
      repeat (3) tick();
      reset = 0;
      tick();
      check_val("rst_outs", outs(), 0);
      check_val("rst_credit", int'(dut.credit), 0);
      check_val("rst_state", int'(dut.state), int'(IDLE));
      detect_10 = 0;
      repeat (2) tick();
      check_val("rst_held_level", int'(dut.credit), 0);

      // Exact-price purchase.
      amount = 9'd100;
      coin(5); coin(10); coin(10); coin(25); coin(25); coin(25);
      check_val("exact_credit", int'(dut.credit), 100);
      do_buy(8);
      check_val("exact_ok", n_ok, 1);
      check_val("exact_returns", n5 + n10 + n25, 0);
      check_val("exact_credit0", int'(dut.credit), 0);
      do_return(8);
      check_val("exact_refund_none", n5 + n10 + n25, 0);

      // Change making: 85 - 60 = 25.
      amount = 9'd60;
      coin(25); coin(25); coin(25); coin(10);
      check_val("chg_credit", int'(dut.credit), 85);
      do_buy(10);
      check_val("chg_ok", n_ok, 1);
      check_val("chg_r25", n25, 1);
      check_val("chg_other", n5 + n10, 0);
      check_val("chg_change0", int'(dut.change), 0);
      check_val("chg_state", int'(dut.state), int'(IDLE));
      check_val("chg_credit0", int'(dut.credit), 0);

      // Insufficient credit, then refund 25,10,5 spaced by one gap cycle.
      amount = 9'd100;
      coin(25); coin(10); coin(5);
      do_buy(6);
      check_val("short_ok", n_ok, 0);
      check_val("short_credit", int'(dut.credit), 40);
      do_return(12);
      check_val("refund_count", seq.size(), 3);
      check_val("refund_onehot", n_multi, 0);
      if (seq.size() >= 3) begin
         check_val("refund_seq0", seq[0], 25);
         check_val("refund_seq1", seq[1], 10);
         check_val("refund_seq2", seq[2], 5);
         check_val("refund_gap1", cyc[1] - cyc[0], 2);
         check_val("refund_gap2", cyc[2] - cyc[1], 2);
      end
      check_val("refund_credit", int'(dut.credit), 0);

      // Empty 25 tube: 50 paid as five 10s.
      empty_25 = 1;
      coin(25); coin(25);
      do_return(20);
      check_val("empty25_r10", n10, 5);
      check_val("empty25_r25", n25, 0);
      check_val("empty25_r5", n5, 0);
      // All tubes empty: nothing paid, credit restored.
      empty_10 = 1; empty_5 = 1;
      coin(25); coin(25);
      do_return(10);
      check_val("allempty_pulses", n5 + n10 + n25, 0);
      check_val("allempty_credit", int'(dut.credit), 50);
      empty_25 = 0; empty_10 = 0; empty_5 = 0;
      do_return(10);
      check_val("drain_r25", n25, 2);
      check_val("drain_credit", int'(dut.credit), 0);

      // Long level counts once.
      detect_10 = 1;
      repeat (50) tick();
      detect_10 = 0;
      repeat (2) tick();
      check_val("held10_credit", int'(dut.credit), 10);

      // buy and return_coins together: purchase wins.
      amount = 9'd10;
      buy = 1; return_coins = 1;
      watch(8);
      buy = 0; return_coins = 0;
      tick();
      check_val("prio_ok", n_ok, 1);
      check_val("prio_returns", n5 + n10 + n25, 0);
      check_val("prio_credit", int'(dut.credit), 0);

      // Price not a multiple of 5: change 7 -> one 5, remainder 2 kept.
      amount = 9'd3;
      coin(10);
      do_buy(10);
      check_val("odd_ok", n_ok, 1);
      check_val("odd_r5", n5, 1);
      check_val("odd_r10", n10, 0);
      check_val("odd_credit", int'(dut.credit), 2);

      // Zero price: 2+5+10=17 -> 10, 5, remainder 2.
      amount = 9'd0;
      coin(5); coin(10);
      do_buy(12);
      check_val("zero_ok", n_ok, 1);
      check_val("zero_r10", n10, 1);
      check_val("zero_r5", n5, 1);
      check_val("zero_credit", int'(dut.credit), 2);
      do_reset();
      check_val("reset2_credit", int'(dut.credit), 0);

      // Reset mid-dispense of a 100 refund.
      coin(25); coin(25); coin(25); coin(25);
      check_val("mid_credit", int'(dut.credit), 100);
      return_coins = 1;
      got = 0;
      for (int i = 0; i < 10 && got == 0; i++) begin
         tick();
         if (return_25) got = 1;
      end
      check_val("mid_first25", got, 1);
      reset = 1;
      tick();
      check_val("mid_rst_outs", outs(), 0);
      check_val("mid_rst_credit", int'(dut.credit), 0);
      check_val("mid_rst_change", int'(dut.change), 0);
      reset = 0;
      watch(12);
      check_val("mid_after_pulses", n_ok + n5 + n10 + n25, 0);
      return_coins = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
